// File: rtl/bpred_resolve_queue_pkg.sv
// Shared types and width helpers for the branch-prediction resolve queue.
package bpred_resolve_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pred_npc;
  } entry_t;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return ptr_w(d) + 1;
  endfunction

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

endpackage

// File: rtl/bpred_resolve_queue_fifo.sv
// In-order storage of predicted branches: pointers, occupancy and a synchronous clear.
module bpred_entry_fifo
  import bpred_resolve_queue_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int depth      = DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [addr_width-1:0] wr_pc,
  input  logic [addr_width-1:0] wr_npc,
  output logic [addr_width-1:0] rd_pc,
  output logic [addr_width-1:0] rd_npc,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);

  logic [addr_width-1:0] pc_mem  [depth];
  logic [addr_width-1:0] npc_mem [depth];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  assign full   = (count == CW'(depth));
  assign empty  = (count == '0);
  assign rd_pc  = pc_mem[head];
  assign rd_npc = npc_mem[head];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !clr) begin
      pc_mem[tail]  <= wr_pc;
      npc_mem[tail] <= wr_npc;
    end
  end

endmodule

// File: rtl/bpred_resolve_queue.sv
// Tracks outstanding branch predictions in order, updates the history table and raises redirects.
module bpred_resolve_queue
  import bpred_resolve_queue_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int depth      = DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENQ_VALID,
  output logic                  ENQ_READY,
  input  logic [addr_width-1:0] ENQ_PC,
  input  logic [addr_width-1:0] ENQ_PRED_NPC,
  input  logic                  RES_VALID,
  output logic                  RES_READY,
  input  logic                  RES_TAKEN,
  input  logic [addr_width-1:0] RES_NPC,
  output logic                  UPD_WE,
  output logic [addr_width-1:0] UPD_PC,
  output logic                  UPD_TAKEN,
  output logic                  MISPRED,
  output logic [addr_width-1:0] REDIRECT_PC,
  output logic [15:0]           RES_CNT,
  output logic [15:0]           MISS_CNT
);

  state_t                state;
  logic                  full;
  logic                  empty;
  logic [addr_width-1:0] head_pc;
  logic [addr_width-1:0] head_npc;
  logic                  enq_fire;
  logic                  res_fire;
  logic                  miss;

  assign ENQ_READY = (state == RUN) && !full;
  assign RES_READY = (state == RUN) && !empty;
  assign enq_fire  = ENQ_VALID && ENQ_READY;
  assign res_fire  = RES_VALID && RES_READY;
  assign miss      = res_fire && (head_npc != RES_NPC);

  // A miss clears the queue; the clear dominates any same-cycle wrong-path enqueue.
  bpred_entry_fifo #(
    .addr_width(addr_width),
    .depth     (depth)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (miss),
    .push  (enq_fire),
    .pop   (res_fire && !miss),
    .wr_pc (ENQ_PC),
    .wr_npc(ENQ_PRED_NPC),
    .rd_pc (head_pc),
    .rd_npc(head_npc),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      UPD_WE      <= 1'b0;
      UPD_PC      <= '0;
      UPD_TAKEN   <= 1'b0;
      MISPRED     <= 1'b0;
      REDIRECT_PC <= '0;
      RES_CNT     <= '0;
      MISS_CNT    <= '0;
    end else begin
      state   <= miss ? FLUSH : RUN;
      UPD_WE  <= res_fire;
      MISPRED <= miss;
      if (res_fire) begin
        UPD_PC    <= head_pc;
        UPD_TAKEN <= RES_TAKEN;
        RES_CNT   <= RES_CNT + 16'd1;
      end
      if (miss) begin
        REDIRECT_PC <= RES_NPC;
        MISS_CNT    <= MISS_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Randomized and directed checks of bpred_resolve_queue against a queue-based reference model.
module tb_bpred_resolve_queue;
  import bpred_resolve_queue_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENQ_VALID, ENQ_READY, RES_VALID, RES_READY, RES_TAKEN;
  logic [31:0] ENQ_PC, ENQ_PRED_NPC, RES_NPC;
  logic        UPD_WE, UPD_TAKEN, MISPRED;
  logic [31:0] UPD_PC, REDIRECT_PC;
  logic [15:0] RES_CNT, MISS_CNT;

  bpred_resolve_queue #(.addr_width(32), .depth(4)) dut (
    .CLK(CLK), .RST(RST),
    .ENQ_VALID(ENQ_VALID), .ENQ_READY(ENQ_READY), .ENQ_PC(ENQ_PC), .ENQ_PRED_NPC(ENQ_PRED_NPC),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_TAKEN(RES_TAKEN), .RES_NPC(RES_NPC),
    .UPD_WE(UPD_WE), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
    .MISPRED(MISPRED), .REDIRECT_PC(REDIRECT_PC), .RES_CNT(RES_CNT), .MISS_CNT(MISS_CNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // reference model state
  entry_t      q[$];
  bit          m_flush;
  bit          e_upd_we, e_upd_taken, e_mispred;
  logic [31:0] e_upd_pc, e_redir;
  logic [15:0] e_res_cnt, e_miss_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    e_upd_we = 0; e_upd_taken = 0; e_mispred = 0;
    e_upd_pc = 0; e_redir = 0; e_res_cnt = 0; e_miss_cnt = 0;
  endtask

  task automatic check_outputs();
    check("upd_we", 32'(UPD_WE), 32'(e_upd_we));
    check("mispred", 32'(MISPRED), 32'(e_mispred));
    check("upd_pc", UPD_PC, e_upd_pc);
    check("upd_taken", 32'(UPD_TAKEN), 32'(e_upd_taken));
    check("redirect_pc", REDIRECT_PC, e_redir);
    check("res_cnt", 32'(RES_CNT), 32'(e_res_cnt));
    check("miss_cnt", 32'(MISS_CNT), 32'(e_miss_cnt));
  endtask

  // One clock: drive at negedge, check readies, advance model, check registered outputs.
  task automatic cycle(input bit ev, input logic [31:0] pc, input logic [31:0] pnpc,
                       input bit rv, input bit taken, input logic [31:0] npc);
    bit     er, rr, ef, rf, miss;
    entry_t h, n;
    @(negedge CLK);
    ENQ_VALID = ev; ENQ_PC = pc; ENQ_PRED_NPC = pnpc;
    RES_VALID = rv; RES_TAKEN = taken; RES_NPC = npc;
    #1;
    er = !m_flush && (q.size() < 4);
    rr = !m_flush && (q.size() != 0);
    check("enq_ready", 32'(ENQ_READY), 32'(er));
    check("res_ready", 32'(RES_READY), 32'(rr));
    ef = ev && er;
    rf = rv && rr;
    miss = 0;
    e_upd_we = rf;
    e_mispred = 0;
    if (rf) begin
      h = q[0];
      miss = (h.pred_npc != npc);
      e_upd_pc = h.pc;
      e_upd_taken = taken;
      e_res_cnt = e_res_cnt + 16'd1;
      if (miss) begin
        e_mispred = 1;
        e_redir = npc;
        e_miss_cnt = e_miss_cnt + 16'd1;
      end
    end
    if (miss) begin
      q.delete();
      m_flush = 1;
    end else begin
      m_flush = 0;
      if (rf) void'(q.pop_front());
      if (ef) begin
        n.pc = pc;
        n.pred_npc = pnpc;
        q.push_back(n);
      end
    end
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    ENQ_VALID = 0; ENQ_PC = 0; ENQ_PRED_NPC = 0;
    RES_VALID = 0; RES_TAKEN = 0; RES_NPC = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    model_reset();
    #1;
    check("rst_enq_ready", 32'(ENQ_READY), 32'd1);
    check("rst_res_ready", 32'(RES_READY), 32'd0);
    check_outputs();
  endtask

  initial begin
    logic [31:0] pc, pn, rn;
    bit          ev, rv;
    model_reset();
    do_reset();

    // basic non-miss resolve
    cycle(1, 32'h100, 32'h104, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 32'h104);
    check("first_upd_pc", UPD_PC, 32'h100);
    check("first_res_cnt", 32'(RES_CNT), 32'd1);

    // fill to depth, hold a 5th enqueue, then enqueue + resolve while full
    for (int i = 0; i < 4; i++) cycle(1, 32'h300 + 32'(i * 4), 32'h400 + 32'(i * 4), 0, 0, 0);
    cycle(1, 32'h3f0, 32'h3f4, 0, 0, 0);
    check("full_not_ready", 32'(ENQ_READY), 32'd0);
    cycle(1, 32'h3f0, 32'h3f4, 1, 1, 32'h400);
    cycle(0, 0, 0, 0, 0, 0);
    while (q.size() != 0) cycle(0, 0, 0, 1, 0, q[0].pred_npc);

    // mispredict on the older of two entries
    cycle(1, 32'h200, 32'h204, 0, 0, 0);
    cycle(1, 32'h204, 32'h208, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h240);
    check("miss_redirect", REDIRECT_PC, 32'h240);
    check("miss_cnt_1", 32'(MISS_CNT), 32'd1);
    cycle(0, 0, 0, 1, 0, 32'h208);
    cycle(0, 0, 0, 1, 0, 32'h208);

    // wrong-path enqueue squashed by a same-cycle mispredict
    cycle(1, 32'h500, 32'h504, 0, 0, 0);
    cycle(1, 32'h600, 32'h604, 1, 0, 32'h550);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 32'h604);
    check("squash_res_ready", 32'(RES_READY), 32'd0);

    // resolve presented on an empty queue
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 32'h700);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ev = ($urandom_range(9) < 6);
      rv = ($urandom_range(9) < 6);
      pc = $urandom & 32'hffff_fffc;
      pn = $urandom & 32'hffff_fffc;
      rn = $urandom & 32'hffff_fffc;
      if (q.size() != 0 && $urandom_range(3) != 0) rn = q[0].pred_npc;
      cycle(ev, pc, pn, rv, 1'($urandom), rn);
    end

    // asynchronous reset between a resolve fire and the next edge
    while (q.size() != 0) cycle(0, 0, 0, 1, 0, q[0].pred_npc);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h800, 32'h804, 0, 0, 0);
    cycle(1, 32'h808, 32'h80c, 0, 0, 0);
    @(negedge CLK);
    RES_VALID = 1; RES_NPC = 32'h804;
    #1;
    RST = 1;
    #1;
    check("arst_upd_we", 32'(UPD_WE), 32'd0);
    check("arst_res_cnt", 32'(RES_CNT), 32'd0);
    @(posedge CLK);
    #1;
    check("arst_edge_upd_we", 32'(UPD_WE), 32'd0);
    check("arst_edge_mispred", 32'(MISPRED), 32'd0);
    @(negedge CLK);
    RST = 0;
    idle_inputs();
    model_reset();
    #1;
    check("arst_enq_ready", 32'(ENQ_READY), 32'd1);
    check("arst_res_ready", 32'(RES_READY), 32'd0);
    cycle(0, 0, 0, 1, 0, 32'h804);

    // RES_CNT wraps after 65536 resolves
    cycle(1, 32'h900, 32'h904, 0, 0, 0);
    for (int i = 0; i < 65536; i++)
      cycle(1, 32'h900 + 32'(i * 4), 32'h904 + 32'(i * 4), 1, i[0], q[0].pred_npc);
    check("res_cnt_wrap", 32'(RES_CNT), 32'd0);
    check("miss_cnt_nowrap", 32'(MISS_CNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
